// File: rtl/pc_trace_buffer_if.sv
// pc_trace_buffer_if: valid/ready drain port carrying one captured (pc, ins) trace entry
interface pc_trace_buffer_if;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_pc;
    logic [31:0] rd_ins;
    modport master (output rd_valid, rd_pc, rd_ins, input rd_ready);
    modport slave (input rd_valid, rd_pc, rd_ins, output rd_ready);
endinterface

// File: rtl/pc_trace_buffer.sv
// pc_trace_buffer: records (pc, ins) on each PC change into a show-ahead FIFO, counting drops when full
module pc_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AW = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       now_pc,
    input  logic [31:0]       ins,
    input  logic              trace_en,
    input  logic              clr_ovf,
    pc_trace_buffer_if.master rd,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic [15:0]       drop_cnt
);
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   last_pc;
    logic          primed;
    logic          cap;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    always_comb begin
        cap  = trace_en & (~primed | (now_pc != last_pc));
        full = count == (AW+1)'(DEPTH);
        pop  = rd.rd_valid & rd.rd_ready;
        push = cap & (~full | pop);
        drop = cap & full & ~pop;
    end
    // Data is masked while empty so unwritten storage never leaks onto the port
    assign rd.rd_valid = count != '0;
    assign rd.rd_pc    = rd.rd_valid ? mem[rd_ptr][63:32] : '0;
    assign rd.rd_ins   = rd.rd_valid ? mem[rd_ptr][31:0] : '0;
    always_ff @(posedge CLK) if (push) mem[wr_ptr] <= {now_pc, ins};
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            last_pc  <= '0;
            primed   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            primed   <= trace_en;
            if (cap) last_pc <= now_pc;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count    <= (push & ~pop) ? count + (AW+1)'(1) : (pop & ~push) ? count - (AW+1)'(1) : count;
            overflow <= ~clr_ovf & (overflow | drop);
            drop_cnt <= clr_ovf ? '0 : (drop & ~&drop_cnt) ? drop_cnt + 16'd1 : drop_cnt;
        end
    end
endmodule

// File: doc/pc_trace_buffer.md
# pc_trace_buffer

Instruction-trace capture buffer that sits directly downstream of the multicycle CPU top (`Main`). It monitors the CPU's `now_pc`/`ins` outputs and records one (PC, instruction) entry each time the PC changes. Entries are held in a show-ahead FIFO and drained through a valid/ready port by a test bench, UART dumper or checker. Drops caused by a full buffer are counted and flagged, never silently lost.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `AW`, 4: log2(DEPTH); must match `DEPTH`.
- `CLK`  in  1  system clock; all state on rising edge.
- `RST`  in  1  reset; asynchronous, active-low (0 = reset asserted).
- `now_pc`  in  32  current PC from CPU.
- `ins`  in  32  instruction at `now_pc` from CPU.
- `trace_en`  in  1  capture enable.
- `clr_ovf`  in  1  synchronous clear of `overflow` and `drop_cnt`.
- `rd_ready`  in  1  consumer accepts head entry.
- `rd_valid`  out  1  head entry valid.
- `rd_pc`  out  32  head entry PC.
- `rd_ins`  out  32  head entry instruction.
- `count`  out  AW+1  entries held, 0..DEPTH.
- `overflow`  out  1  sticky: at least one capture dropped.
- `drop_cnt`  out  16  dropped captures, saturating at 16'hFFFF.

## Operation
- State: `last_pc` (32), `primed` (1), FIFO storage, `wr_ptr`/`rd_ptr` (AW bits, natural wrap), `count`, `overflow`, `drop_cnt`.
- Capture condition `cap` (per rising edge): `trace_en=1` and (`primed=0` or `now_pc != last_pc`).
- On `cap`: `last_pc <= now_pc`, `primed <= 1`; entry {now_pc, ins} is written if not full, otherwise dropped.
- `trace_en=0`: no capture; `primed <= 0`, so re-enable always captures the current PC even if unchanged.
- A branch-to-self (PC stays constant) produces exactly one entry; this is the specified behaviour.
- Read: `rd_valid = (count != 0)`; pop when `rd_valid & rd_ready`. `rd_ready` while empty is ignored.
- Full definition: `count == DEPTH`. A push while full is accepted only when a pop occurs in the same cycle.
- Simultaneous push and pop: `count` is unchanged; both pointers advance.
- Dropped push: `overflow <= 1`, `drop_cnt <= drop_cnt + 1`, saturating.
- `clr_ovf=1`: `overflow <= 0`, `drop_cnt <= 0`. If a drop occurs in the same cycle, `clr_ovf` wins over the drop; `overflow` becomes 0 and `drop_cnt` becomes 0.
- No bypass path: a capture into an empty FIFO is not visible on `rd_*` in the same cycle.

## Timing
- Reset (`RST=0`, asynchronous): `rd_valid=0`, `rd_pc=0`, `rd_ins=0`, `count=0`, `overflow=0`, `drop_cnt=0`, `primed=0`, `last_pc=0`, pointers at 0. Storage contents are don't-care but must read as 0 on `rd_*` while empty.
- Reset mid-operation discards all entries immediately. Release is treated as synchronous to `CLK` by the integrator.
- Capture-to-visible latency is 1 cycle. A PC sampled at edge N sets `rd_valid` and the matching `rd_pc`/`rd_ins` after edge N.
- Pop latency: on the edge with `rd_valid & rd_ready`, the next entry (or `rd_valid=0`) appears after that edge.
- The `rd_*` data must stay stable while `rd_valid=1` and `rd_ready=0`.
- `count` and `overflow` are registered and update on the same edge as the push/pop that causes them.
- Sustained throughput is 1 push and 1 pop per cycle; the CPU changes PC at most once per multicycle instruction.

## Test plan
- Reset then enable: `RST=0`, then 1, `trace_en=1`, `now_pc=4`, `ins=32'h2002000A` held for 5 cycles -> exactly 1 entry; `rd_pc=4`, `rd_ins=32'h2002000A`, `count=1`.
- PC sequence 4, 8, 8, 8, 12 with `rd_ready=0` -> `count=3`; draining with `rd_ready=1` yields 4, 8, 12 in order, then `rd_valid=0`.
- With `DEPTH=16` and `rd_ready=0`, apply 20 distinct PCs (0, 4, …, 76) -> `count=16`, `overflow=1`, `drop_cnt=4`, head `rd_pc=0`. Then pulse `clr_ovf` -> `overflow=0`, `drop_cnt=0`.
- Full FIFO with `rd_ready=1` and a new PC in the same cycle -> push accepted, `count` stays 16, `drop_cnt` unchanged, head advances to PC 4.
- Toggle `trace_en` 1 -> 0 -> 1 with `now_pc=32'h40` held constant -> two entries with PC 32'h40 (one per enable period).
- Assert `RST=0` mid-stream with `count=7` -> `rd_valid=0` and `count=0` without waiting for a clock edge; after release, the next PC is captured as the first entry.
